urv_dm_ahb_bridge: RTL and testbench
====================================

Name: urv_dm_ahb_bridge

Overview:
- Bridges the urv_cpu data-memory port (dm_*) onto an AHB-Lite master port. Sits directly downstream of the CPU data interface.
- Replaces the ad-hoc byte-array data memory with any AHB-Lite slave, e.g. cmsdk_ahb_ram_beh or a bus matrix.
- Single outstanding transfer, non-pipelined: one request in flight until its data phase completes.

Parameters:
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged, data).
- ERR_DATA, 32'h0000_0000, value returned on dm_data_l_o when a load gets an error response.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- dm_addr_i  in  32  CPU byte address.
- dm_data_s_i  in  32  store data, already lane-positioned by the CPU.
- dm_data_select_i  in  4  byte-lane enables.
- dm_store_i  in  1  store request.
- dm_load_i  in  1  load request.
- dm_ready_o  out  1  bridge idle; a request is accepted only when high.
- dm_data_l_o  out  32  load data, raw 32-bit lane word.
- dm_load_done_o  out  1  one-cycle pulse; load data valid.
- dm_store_done_o  out  1  one-cycle pulse; store complete.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HSIZE  out  3  byte (000), half (001) or word (010).
- HWRITE  out  1  write control.
- HWDATA  out  32  write data.
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HMASTLOCK  out  1  constant 0.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer done / bus ready.
- HRESP  in  1  1 = ERROR.

Behaviour:
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0, dm_ready_o=1, dm_load_done_o=0, dm_store_done_o=0, dm_data_l_o=0. State is IDLE.
- State machine IDLE -> ADDR -> DATA -> IDLE:
  - IDLE: dm_ready_o=1. On (dm_load_i|dm_store_i), register addr, select, store data and write flag; go to ADDR. If both load and store are asserted, store wins.
  - ADDR: drive HTRANS=NONSEQ, HADDR, HSIZE, HWRITE; dm_ready_o=0. Hold these until HREADY=1 is sampled, then go to DATA with HTRANS=IDLE.
  - DATA: HWDATA holds the registered store data for the whole phase. Wait while HREADY=0. On HREADY=1:
    - load: capture HRDATA into dm_data_l_o.
    - store/load: pulse the matching done for one cycle in the next cycle, and return to IDLE.
- Minimum latency with a zero-wait slave: request sampled in cycle 0, address phase in cycle 1, data phase in cycle 2, done pulse and dm_ready_o=1 in cycle 3. Each HREADY=0 cycle adds one cycle.
- A new request may be accepted in the same cycle the done pulse is high; dm_ready_o is 1 in that cycle.
- Size/alignment mapping from dm_data_select_i:
  - 1111 -> word, HADDR[1:0]=00.
  - 0011 -> half, HADDR[1:0]=00; 1100 -> half, HADDR[1:0]=10.
  - 0001/0010/0100/1000 -> byte, HADDR[1:0]=00/01/10/11.
  - Any other pattern -> word, HADDR[1:0]=00 (the CPU never issues these).
- HADDR[31:2] is always dm_addr_i[31:2].
- Load data is passed through unshifted; the CPU performs lane extraction and sign extension.
- Error response: HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1. The transfer completes on the second cycle with a normal done pulse; load data = ERR_DATA.
- Requests arriving while dm_ready_o=0 are ignored. The CPU must hold them until dm_ready_o returns high.
- Reset asserted mid-transfer: all outputs go to reset values immediately; no done pulse is issued.

Optional Feature:
- Macro URV_DM_BUS_ERR_EN.
- When defined:
  - Extra outputs bus_err_o (1 bit) and bus_err_addr_o (32 bits).
  - bus_err_o pulses in the same cycle as the done pulse of an errored transfer.
  - bus_err_addr_o latches that transfer's full dm address and holds it until the next error. Reset value is 0.
- When undefined: those ports are absent; errors are signalled only through ERR_DATA.

Test Plan:
- Word load at 0x0000_0100, zero-wait slave returning 0xDEADBEEF -> HADDR=0x100, HSIZE=010, HWRITE=0 in cycle 1; dm_load_done_o=1 and dm_data_l_o=0xDEADBEEF in cycle 3.
- Byte store select=0100, addr 0x0000_0203, data 0x00AB0000 -> HADDR=0x202, HSIZE=000, HWDATA=0x00AB0000; dm_store_done_o pulses once.
- Halfword load select=1100 with 3 HREADY=0 wait states in the data phase -> HADDR[1:0]=10, HSIZE=001; done arrives in cycle 6; dm_ready_o=0 in cycles 1-5.
- Two-cycle ERROR response on a load -> dm_data_l_o=ERR_DATA, done pulses once. With URV_DM_BUS_ERR_EN: bus_err_o=1 in the same cycle and bus_err_addr_o=request address.
- rst_i low during the DATA phase -> HTRANS=00 and dm_ready_o=1 with no clock edge; no done pulse; a new load after reset completes normally.
- Back-to-back store then load, with the second request presented in the done cycle -> the second address phase starts in the cycle after the done pulse; no request is lost or duplicated.

Source files
------------

// File: rtl/urv_dm_ahb_bridge.sv
// Bridges the urv_cpu data-memory port onto a single-outstanding, non-pipelined AHB-Lite master.
// Optional macro URV_DM_BUS_ERR_EN adds bus_err_o / bus_err_addr_o error reporting ports.
module urv_dm_ahb_bridge #(
  parameter logic [3:0]  HPROT_VAL = 4'b0011,
  parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
`ifdef URV_DM_BUS_ERR_EN
  ,
  output logic        bus_err_o,
  output logic [31:0] bus_err_addr_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        req;
  logic        accept;
  logic        complete;
  logic [2:0]  sel_size;
  logic [1:0]  sel_lo;

  logic [31:0] haddr_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic [31:0] data_l_q;
  logic        load_done_q;
  logic        store_done_q;

  assign req      = dm_load_i | dm_store_i;
  assign accept   = (state == ST_IDLE) && req;
  assign complete = (state == ST_DATA) && HREADY;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req)    state_nxt = ST_ADDR;
      ST_ADDR: if (HREADY) state_nxt = ST_DATA;
      ST_DATA: if (HREADY) state_nxt = ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    HTRANS     = 2'b00;
    dm_ready_o = 1'b0;
    case (state)
      ST_IDLE: dm_ready_o = 1'b1;
      ST_ADDR: HTRANS     = 2'b10;
      default: ;
    endcase
  end

  // Unlisted select patterns fall back to an aligned word access.
  always_comb begin
    sel_size = 3'b010;
    sel_lo   = 2'b00;
    case (dm_data_select_i)
      4'b0011: begin sel_size = 3'b001; sel_lo = 2'b00; end
      4'b1100: begin sel_size = 3'b001; sel_lo = 2'b10; end
      4'b0001: begin sel_size = 3'b000; sel_lo = 2'b00; end
      4'b0010: begin sel_size = 3'b000; sel_lo = 2'b01; end
      4'b0100: begin sel_size = 3'b000; sel_lo = 2'b10; end
      4'b1000: begin sel_size = 3'b000; sel_lo = 2'b11; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      haddr_q      <= 32'h0;
      hsize_q      <= 3'b010;
      hwrite_q     <= 1'b0;
      hwdata_q     <= 32'h0;
      data_l_q     <= 32'h0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      if (accept) begin
        haddr_q  <= {dm_addr_i[31:2], sel_lo};
        hsize_q  <= sel_size;
        hwrite_q <= dm_store_i;
        hwdata_q <= dm_data_s_i;
      end
      if (complete && !hwrite_q) begin
        data_l_q <= HRESP ? ERR_DATA : HRDATA;
      end
      load_done_q  <= complete && !hwrite_q;
      store_done_q <= complete && hwrite_q;
    end
  end

`ifdef URV_DM_BUS_ERR_EN
  logic [31:0] req_addr_q;
  logic        bus_err_q;
  logic [31:0] bus_err_addr_q;

  // The full byte address is kept separately because HADDR[1:0] comes from the lane select.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_addr_q     <= 32'h0;
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= 32'h0;
    end else begin
      if (accept) begin
        req_addr_q <= dm_addr_i;
      end
      bus_err_q <= complete && HRESP;
      if (complete && HRESP) begin
        bus_err_addr_q <= req_addr_q;
      end
    end
  end

  assign bus_err_o      = bus_err_q;
  assign bus_err_addr_o = bus_err_addr_q;
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^dm_addr_i[1:0];
`endif

  assign HADDR           = haddr_q;
  assign HSIZE           = hsize_q;
  assign HWRITE          = hwrite_q;
  assign HWDATA          = hwdata_q;
  assign HBURST          = 3'b000;
  assign HPROT           = HPROT_VAL;
  assign HMASTLOCK       = 1'b0;
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;

endmodule

// File: tb/tb_urv_dm_ahb_bridge.sv
// Directed self-checking bench for urv_dm_ahb_bridge; the bench itself plays the AHB slave.
module tb_urv_dm_ahb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] dm_addr_i = 32'h0;
  logic [31:0] dm_data_s_i = 32'h0;
  logic [3:0]  dm_data_select_i = 4'h0;
  logic        dm_store_i = 1'b0;
  logic        dm_load_i = 1'b0;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
`ifdef URV_DM_BUS_ERR_EN
  logic        bus_err_o;
  logic [31:0] bus_err_addr_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  urv_dm_ahb_bridge dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_store_i       (dm_store_i),
    .dm_load_i        (dm_load_i),
    .dm_ready_o       (dm_ready_o),
    .dm_data_l_o      (dm_data_l_o),
    .dm_load_done_o   (dm_load_done_o),
    .dm_store_done_o  (dm_store_done_o),
    .HADDR            (HADDR),
    .HTRANS           (HTRANS),
    .HSIZE            (HSIZE),
    .HWRITE           (HWRITE),
    .HWDATA           (HWDATA),
    .HBURST           (HBURST),
    .HPROT            (HPROT),
    .HMASTLOCK        (HMASTLOCK),
    .HRDATA           (HRDATA),
    .HREADY           (HREADY),
    .HRESP            (HRESP)
`ifdef URV_DM_BUS_ERR_EN
    ,
    .bus_err_o        (bus_err_o),
    .bus_err_addr_o   (bus_err_addr_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] sel);
    dm_load_i        = ld;
    dm_store_i       = st;
    dm_addr_i        = addr;
    dm_data_s_i      = data;
    dm_data_select_i = sel;
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [3:0]  sel_tab   [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b0101};
  logic [31:0] haddr_tab [6] = '{32'h40, 32'h41, 32'h43, 32'h40, 32'h40, 32'h40};
  logic [2:0]  hsize_tab [6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b010};

  initial begin
    #12;
    checkOutput("rst htrans", 32'(HTRANS), 32'h0);
    checkOutput("rst haddr", HADDR, 32'h0);
    checkOutput("rst hsize", 32'(HSIZE), 32'h2);
    checkOutput("rst hwrite", 32'(HWRITE), 32'h0);
    checkOutput("rst hwdata", HWDATA, 32'h0);
    checkOutput("rst ready", 32'(dm_ready_o), 32'h1);
    checkOutput("rst load_done", 32'(dm_load_done_o), 32'h0);
    checkOutput("rst store_done", 32'(dm_store_done_o), 32'h0);
    checkOutput("rst data_l", dm_data_l_o, 32'h0);
    checkOutput("rst consts", {21'h0, HBURST, HPROT, 3'b0, HMASTLOCK}, {21'h0, 3'b000, 4'b0011, 4'b0000});
`ifdef URV_DM_BUS_ERR_EN
    checkOutput("rst bus_err_addr", bus_err_addr_o, 32'h0);
`endif
    step();
    rst_i = 1'b1;

    // Word load, zero-wait slave
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b1111);
    HRDATA = 32'hDEAD_BEEF;
    step();
    checkOutput("wl c1 htrans", 32'(HTRANS), 32'h2);
    checkOutput("wl c1 haddr", HADDR, 32'h100);
    checkOutput("wl c1 hsize", 32'(HSIZE), 32'h2);
    checkOutput("wl c1 hwrite", 32'(HWRITE), 32'h0);
    checkOutput("wl c1 ready", 32'(dm_ready_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    checkOutput("wl c2 htrans", 32'(HTRANS), 32'h0);
    checkOutput("wl c2 load_done", 32'(dm_load_done_o), 32'h0);
    step();
    checkOutput("wl c3 load_done", 32'(dm_load_done_o), 32'h1);
    checkOutput("wl c3 data_l", dm_data_l_o, 32'hDEAD_BEEF);
    checkOutput("wl c3 ready", 32'(dm_ready_o), 32'h1);
    step();
    checkOutput("wl c4 load_done", 32'(dm_load_done_o), 32'h0);

    // Byte store, lane 2
    applyStimulus(1'b0, 1'b1, 32'h0000_0203, 32'h00AB_0000, 4'b0100);
    step();
    checkOutput("bs c1 haddr", HADDR, 32'h202);
    checkOutput("bs c1 hsize", 32'(HSIZE), 32'h0);
    checkOutput("bs c1 hwrite", 32'(HWRITE), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    checkOutput("bs c2 hwdata", HWDATA, 32'h00AB_0000);
    step();
    checkOutput("bs c3 store_done", 32'(dm_store_done_o), 32'h1);
    checkOutput("bs c3 load_done", 32'(dm_load_done_o), 32'h0);
    step();
    checkOutput("bs c4 store_done", 32'(dm_store_done_o), 32'h0);

    // Halfword load with three data-phase wait states
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'b1100);
    HRDATA = 32'hCAFE_0000;
    step();
    checkOutput("hw c1 haddr", HADDR, 32'h302);
    checkOutput("hw c1 hsize", 32'(HSIZE), 32'h1);
    checkOutput("hw c1 ready", 32'(dm_ready_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    HREADY = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      checkOutput($sformatf("hw c%0d ready", c), 32'(dm_ready_o), 32'h0);
      checkOutput($sformatf("hw c%0d load_done", c), 32'(dm_load_done_o), 32'h0);
      if (c == 5) HREADY = 1'b1;
      step();
    end
    checkOutput("hw c6 load_done", 32'(dm_load_done_o), 32'h1);
    checkOutput("hw c6 data_l", dm_data_l_o, 32'hCAFE_0000);
    checkOutput("hw c6 ready", 32'(dm_ready_o), 32'h1);
    step();

    // Word store with one address-phase wait state
    applyStimulus(1'b0, 1'b1, 32'h0000_0500, 32'h0000_0077, 4'b1111);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    HREADY = 1'b0;
    step();
    checkOutput("aw c2 htrans", 32'(HTRANS), 32'h2);
    checkOutput("aw c2 haddr", HADDR, 32'h500);
    HREADY = 1'b1;
    step();
    checkOutput("aw c3 htrans", 32'(HTRANS), 32'h0);
    checkOutput("aw c3 hwdata", HWDATA, 32'h77);
    checkOutput("aw c3 store_done", 32'(dm_store_done_o), 32'h0);
    step();
    checkOutput("aw c4 store_done", 32'(dm_store_done_o), 32'h1);
    step();

    // Two-cycle ERROR response on a load
    applyStimulus(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'b1111);
    step();
    checkOutput("er c1 htrans", 32'(HTRANS), 32'h2);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    HRESP  = 1'b1;
    HREADY = 1'b0;
    HRDATA = 32'h1234_5678;
    step();
    checkOutput("er c3 load_done", 32'(dm_load_done_o), 32'h0);
    checkOutput("er c3 ready", 32'(dm_ready_o), 32'h0);
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    checkOutput("er c4 load_done", 32'(dm_load_done_o), 32'h1);
    checkOutput("er c4 data_l", dm_data_l_o, 32'h0);
`ifdef URV_DM_BUS_ERR_EN
    checkOutput("er c4 bus_err", 32'(bus_err_o), 32'h1);
    checkOutput("er c4 bus_err_addr", bus_err_addr_o, 32'h404);
`endif
    step();
    checkOutput("er c5 load_done", 32'(dm_load_done_o), 32'h0);
`ifdef URV_DM_BUS_ERR_EN
    checkOutput("er c5 bus_err", 32'(bus_err_o), 32'h0);
    checkOutput("er c5 bus_err_addr", bus_err_addr_o, 32'h404);
`endif

    // Reset asserted during the data phase
    applyStimulus(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'b1111);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("mr htrans", 32'(HTRANS), 32'h0);
    checkOutput("mr ready", 32'(dm_ready_o), 32'h1);
    checkOutput("mr haddr", HADDR, 32'h0);
    checkOutput("mr data_l", dm_data_l_o, 32'h0);
    step();
    checkOutput("mr load_done", 32'(dm_load_done_o), 32'h0);
    rst_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'b1111);
    HRDATA = 32'h55AA_55AA;
    step();
    checkOutput("mr c1 haddr", HADDR, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    checkOutput("mr c3 load_done", 32'(dm_load_done_o), 32'h1);
    checkOutput("mr c3 data_l", dm_data_l_o, 32'h55AA_55AA);
    step();

    // Back-to-back store then load, second request in the done cycle
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222, 4'b1111);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    checkOutput("bb c2 hwdata", HWDATA, 32'h1111_2222);
    step();
    checkOutput("bb c3 store_done", 32'(dm_store_done_o), 32'h1);
    checkOutput("bb c3 ready", 32'(dm_ready_o), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b1111);
    HRDATA = 32'h3333_4444;
    step();
    checkOutput("bb c4 htrans", 32'(HTRANS), 32'h2);
    checkOutput("bb c4 haddr", HADDR, 32'h20);
    checkOutput("bb c4 hwrite", 32'(HWRITE), 32'h0);
    checkOutput("bb c4 store_done", 32'(dm_store_done_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    checkOutput("bb c6 load_done", 32'(dm_load_done_o), 32'h1);
    checkOutput("bb c6 store_done", 32'(dm_store_done_o), 32'h0);
    checkOutput("bb c6 data_l", dm_data_l_o, 32'h3333_4444);
    step();
    checkOutput("bb c7 htrans", 32'(HTRANS), 32'h0);
    checkOutput("bb c7 load_done", 32'(dm_load_done_o), 32'h0);

    // Lane-select mapping table; load and store both asserted so store must win
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0000_0043, 32'h5A5A_5A5A, sel_tab[i]);
      step();
      checkOutput($sformatf("lane%0d haddr", i), HADDR, haddr_tab[i]);
      checkOutput($sformatf("lane%0d hsize", i), 32'(HSIZE), 32'(hsize_tab[i]));
      checkOutput($sformatf("lane%0d hwrite", i), 32'(HWRITE), 32'h1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      step();
      checkOutput($sformatf("lane%0d store_done", i), 32'(dm_store_done_o), 32'h1);
      checkOutput($sformatf("lane%0d load_done", i), 32'(dm_load_done_o), 32'h0);
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
